// File: rtl/uart_cal_ctrl.sv
// uart_cal_ctrl: parses "A op B =" ASCII expressions from a byte UART, evaluates +,-,*
// on 8-bit unsigned operands and replies with the signed decimal result followed by CR LF.
module uart_cal_ctrl #(
  parameter int unsigned MAX_DIG = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy
);
  localparam int unsigned CW = $clog2(MAX_DIG + 1);
  localparam logic [7:0] CR = 8'h0d;
  localparam logic [7:0] LF = 8'h0a;

  typedef enum logic [2:0] {OPA, OPB, CALC, CONV, SEND, WAIT_HI, WAIT_LO} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

  state_t        state, next;
  op_t           op, op_in;
  logic [7:0]    a, b;
  logic [CW-1:0] cnt;
  logic [15:0]   bin, bin_sh, mag;
  logic          neg;
  logic [19:0]   bcd, bcd_adj, bcd_sh;
  logic [3:0]    conv_cnt;
  logic [7:0]    q [8];
  logic [7:0]    q_load [8];
  logic [2:0]    rd, last, last_load, idx;
  logic          last_sent, started;
  logic [3:0]    dig;

  logic          is_digit, is_ws, is_op, is_eq;
  logic [11:0]   acc;
  logic          accept_digit, latch_op, err;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_ws    = (rx_data == 8'h20) || (rx_data == CR) || (rx_data == LF);
  assign is_op    = (rx_data == 8'h2b) || (rx_data == 8'h2d) || (rx_data == 8'h2a);
  assign is_eq    = (rx_data == 8'h3d);
  assign acc      = {4'd0, (state == OPB) ? b : a} * 12'd10 + {8'd0, rx_data[3:0]};
  assign busy     = (state != OPA) && (state != OPB);

  always_comb begin
    case (rx_data)
      8'h2b:   op_in = OP_ADD;
      8'h2d:   op_in = OP_SUB;
      default: op_in = OP_MUL;
    endcase
  end

  always_comb begin
    case (op)
      OP_ADD:  mag = {8'd0, a} + {8'd0, b};
      OP_SUB:  mag = (a >= b) ? {8'd0, a - b} : {8'd0, b - a};
      default: mag = {8'd0, a} * {8'd0, b};
    endcase
  end

  // One shift-add-3 step; the 16th step's result feeds the reply builder directly.
  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    bcd_sh = {bcd_adj[18:0], bin[15]};
    bin_sh = {bin[14:0], 1'b0};
  end

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) q_load[i] = '0;
    idx       = '0;
    started   = 1'b0;
    dig       = '0;
    last_load = 3'd2;
    if (state == CONV) begin
      if (neg) begin
        q_load[idx] = 8'h2d;
        idx = idx + 3'd1;
      end
      for (int unsigned i = 0; i < 5; i++) begin
        dig = bcd_sh[4*(4-i) +: 4];
        if ((dig != 4'd0) || started || (i == 4)) begin
          q_load[idx] = {4'h3, dig};
          idx = idx + 3'd1;
          started = 1'b1;
        end
      end
      q_load[idx]        = CR;
      q_load[idx + 3'd1] = LF;
      last_load          = idx + 3'd1;
    end else begin
      q_load[0] = 8'h45;
      q_load[1] = CR;
      q_load[2] = LF;
    end
  end

  always_comb begin
    next         = state;
    accept_digit = 1'b0;
    latch_op     = 1'b0;
    err          = 1'b0;
    case (state)
      OPA, OPB: begin
        if (rx_valid && !is_ws) begin
          if (is_digit) begin
            if ((cnt == CW'(MAX_DIG)) || (acc > 12'd255)) err = 1'b1;
            else accept_digit = 1'b1;
          end else if ((state == OPA) && is_op && (cnt != '0)) begin
            latch_op = 1'b1;
            next     = OPB;
          end else if ((state == OPB) && is_eq && (cnt != '0)) begin
            next = CALC;
          end else begin
            err = 1'b1;
          end
        end
        if (err) next = SEND;
      end
      CALC:    next = CONV;
      CONV:    if (conv_cnt == 4'd15) next = SEND;
      SEND:    if (!tx_busy) next = WAIT_HI;
      WAIT_HI: if (tx_busy) next = WAIT_LO;
      WAIT_LO: if (!tx_busy) next = last_sent ? OPA : SEND;
      default: next = OPA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OPA;
      op        <= OP_ADD;
      a         <= '0;
      b         <= '0;
      cnt       <= '0;
      bin       <= '0;
      neg       <= 1'b0;
      bcd       <= '0;
      conv_cnt  <= '0;
      rd        <= '0;
      last      <= '0;
      last_sent <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      for (int unsigned i = 0; i < 8; i++) q[i] <= '0;
    end else begin
      state    <= next;
      tx_valid <= 1'b0;
      case (state)
        OPA, OPB: begin
          if (accept_digit) begin
            if (state == OPA) a <= acc[7:0];
            else b <= acc[7:0];
            cnt <= cnt + CW'(1);
          end
          if (latch_op) begin
            op  <= op_in;
            cnt <= '0;
          end
          if (err) begin
            a         <= '0;
            b         <= '0;
            cnt       <= '0;
            q         <= q_load;
            last      <= last_load;
            rd        <= '0;
            last_sent <= 1'b0;
          end
        end
        CALC: begin
          bin      <= mag;
          neg      <= (op == OP_SUB) && (a < b);
          bcd      <= '0;
          conv_cnt <= '0;
        end
        CONV: begin
          bcd      <= bcd_sh;
          bin      <= bin_sh;
          conv_cnt <= conv_cnt + 4'd1;
          if (conv_cnt == 4'd15) begin
            q         <= q_load;
            last      <= last_load;
            rd        <= '0;
            last_sent <= 1'b0;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_valid  <= 1'b1;
            tx_data   <= q[rd];
            rd        <= rd + 3'd1;
            last_sent <= (rd == last);
          end
        end
        WAIT_LO: begin
          if (!tx_busy && last_sent) begin
            a   <= '0;
            b   <= '0;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cal_ctrl.sv
// Self-checking bench for uart_cal_ctrl: a string-level calculator model predicts each reply,
// and a negedge monitor scores every transmitted byte while emulating the UART busy window.
module tb_uart_cal_ctrl;
  localparam int unsigned MAX_DIG = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;

  int unsigned  tests = 0, fails = 0;
  byte unsigned exp_q[$];
  int unsigned  busy_len = 20, busy_left = 0;
  int unsigned  tx_cnt = 0, cyc = 0, rise_cyc = 0, first_lat = 0, busy_drop = 0;
  logic         first_pend = 1'b0, prev_valid = 1'b0, prev_busy = 1'b0, in_reply = 1'b0;

  uart_cal_ctrl #(.MAX_DIG(MAX_DIG)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_str(input string name, input string act, input string req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual len %0d required len %0d (content differs)", name, act.len(), req.len());
    end
  endtask

  // Reference calculator working on the whole expression string.
  function automatic string model(input string s);
    int unsigned  ph = 0, nd = 0;
    int           v[2];
    int           r;
    byte unsigned c, opc = 8'h00;
    v[0] = 0;
    v[1] = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h20 || c == 8'h0d || c == 8'h0a) continue;
      if (c >= 8'h30 && c <= 8'h39) begin
        nd++;
        v[ph] = v[ph] * 10 + int'(c) - 48;
        if (nd > MAX_DIG || v[ph] > 255) return "E\015\012";
        continue;
      end
      if (ph == 0 && nd > 0 && (c == 8'h2b || c == 8'h2d || c == 8'h2a)) begin
        opc = c;
        ph  = 1;
        nd  = 0;
        continue;
      end
      if (ph == 1 && nd > 0 && c == 8'h3d) begin
        case (opc)
          8'h2b:   r = v[0] + v[1];
          8'h2d:   r = v[0] - v[1];
          default: r = v[0] * v[1];
        endcase
        if (r < 0) return $sformatf("-%0d\015\012", -r);
        return $sformatf("%0d\015\012", r);
      end
      return "E\015\012";
    end
    return "";
  endfunction

  function automatic string gen_expr();
    int unsigned  k = $urandom_range(0, 9);
    int unsigned  a = $urandom_range(0, 255);
    int unsigned  b = $urandom_range(0, 255);
    byte unsigned opc;
    string        sa, sb;
    string        pre = "";
    string        mid = "";
    case ($urandom_range(0, 2))
      0:       opc = 8'h2b;
      1:       opc = 8'h2d;
      default: opc = 8'h2a;
    endcase
    if (k == 0) a = $urandom_range(256, 999);
    if (k == 1) b = $urandom_range(256, 999);
    if (k == 2) opc = 8'h2f;
    sa = $sformatf("%0d", a);
    sb = $sformatf("%0d", b);
    if (k == 3) sa = {"0", sa};
    if (k == 4) sb = "";
    if (k == 5) sa = "";
    if (k == 6) begin
      pre = " \015\012";
      mid = " ";
    end
    return $sformatf("%s%s%s%c%s%s=", pre, sa, mid, opc, mid, sb);
  endfunction

  // Monitor, scoreboard and UART transmitter emulation share one process to keep ordering fixed.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (busy && !prev_busy) begin
      rise_cyc   = cyc;
      first_pend = 1'b1;
    end
    if (rst) in_reply = 1'b0;
    if (in_reply && !busy) busy_drop++;
    if (tx_valid) begin
      check("tx_gap", prev_valid, 0);
      check("tx_pace", tx_busy, 0);
      check("busy_at_tx", busy, 1);
      if (first_pend) begin
        first_lat  = cyc - rise_cyc;
        first_pend = 1'b0;
      end
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: actual byte %0h required none", tx_data);
      end else begin
        check("tx_data", tx_data, exp_q.pop_front());
      end
      in_reply = (exp_q.size() != 0);
      tx_cnt++;
    end
    prev_valid = tx_valid;
    prev_busy  = busy;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end else if (tx_valid) begin
      tx_busy   = 1'b1;
      busy_left = busy_len;
    end
  end

  task automatic send_byte(input byte unsigned v);
    @(negedge clk);
    rx_data  = v;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic wait_reply(input string name);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy || tx_busy) && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_done"}, exp_q.size(), 0);
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic run(input string s, input string reply);
    expect_str(reply);
    send_str(s);
    wait_reply(s);
  endtask

  initial begin
    int unsigned base, n;
    string       s;

    repeat (3) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check_str("model_add", model("12+34="), "46\015\012");
    check_str("model_neg", model("3-10="), "-7\015\012");
    check_str("model_zero", model("7-7="), "0\015\012");
    check_str("model_mul", model("255*255="), "65025\015\012");
    check_str("model_err", model("1234+1="), "E\015\012");

    run("12+34=", "46\015\012");
    check("lat_add", first_lat, 18);
    busy_drop = 0;
    run("255*255=", "65025\015\012");
    check("lat_mul", first_lat, 18);
    check("busy_held", busy_drop, 0);
    run("3-10=", "-7\015\012");
    run("7-7=", "0\015\012");
    run("256+1=", "E\015\012");
    run("+5=", "E\015\012");
    run("12/3=", "E\015\012");
    run("1234+1=", "E\015\012");

    // Slow transmitter with junk bytes arriving while the reply is in flight.
    busy_len = 100;
    expect_str("46\015\012");
    send_str("12+34=");
    for (int i = 0; i < 10; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      repeat (18) @(negedge clk);
    end
    wait_reply("slow_inject");

    // Reset in the middle of the second reply byte.
    busy_len = 20;
    base = tx_cnt;
    expect_str("5535\015\012");
    send_str("123*45=");
    n = 0;
    while (tx_cnt - base < 2 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_mid_reached", tx_cnt - base, 2);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst2_tx_valid", tx_valid, 0);
    check("rst2_tx_data", tx_data, 0);
    check("rst2_busy", busy, 0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    run("1+1=", "2\015\012");

    for (int i = 0; i < 40; i++) begin
      busy_len = $urandom_range(20, 40);
      s = gen_expr();
      run(s, model(s));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end
endmodule
